// File: rtl/cnt_prog.sv
// cnt_prog: parametrised programmable up/down counter.
// Successor of the free-running 3-bit counter: generic width and modulus,
// enable, synchronous clear, clamped parallel load, wrap or saturate at the
// range ends, combinational terminal count and a registered wrap pulse that
// lets several stages be cascaded into a wider timebase.

module cnt_prog #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX     = 255,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap_p,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_r;
  logic             wrap_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             wrap_nxt_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             above_max_s;
  logic [WIDTH-1:0] load_clamp_s;

  // Range compares on the current count and the clamped load value.
  always_comb begin
    at_max_s     = (cnt_r == MAX_C);
    at_zero_s    = (cnt_r == ZERO_C);
    above_max_s  = (cnt_r > MAX_C);
    if (load_val > MAX_C) begin
      load_clamp_s = MAX_C;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Next-state selection with priority clr > load > en > hold.
  // The +1/-1 paths are only taken strictly inside 0..MAX, so the result
  // never relies on natural WIDTH overflow; range ends are handled explicitly.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    wrap_nxt_s = 1'b0;
    if (clr) begin
      cnt_nxt_s  = ZERO_C;
      wrap_nxt_s = 1'b0;
    end else if (load) begin
      cnt_nxt_s  = load_clamp_s;
      wrap_nxt_s = 1'b0;
    end else if (en) begin
      if (dir) begin
        if (above_max_s) begin
          // Illegal state recovery: restart from the bottom of the range.
          cnt_nxt_s  = ZERO_C;
          wrap_nxt_s = 1'b0;
        end else if (at_max_s) begin
          if (sat) begin
            cnt_nxt_s  = MAX_C;
            wrap_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s  = ZERO_C;
            wrap_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s  = cnt_r + ONE_C;
          wrap_nxt_s = 1'b0;
        end
      end else begin
        if (above_max_s) begin
          // Illegal state recovery: re-enter at the top of the range.
          cnt_nxt_s  = MAX_C;
          wrap_nxt_s = 1'b0;
        end else if (at_zero_s) begin
          if (sat) begin
            cnt_nxt_s  = ZERO_C;
            wrap_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s  = MAX_C;
            wrap_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s  = cnt_r - ONE_C;
          wrap_nxt_s = 1'b0;
        end
      end
    end else begin
      cnt_nxt_s  = cnt_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // Count and wrap-pulse registers; asynchronous reset discards any count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= RST_C;
      wrap_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  // Terminal count is combinational so it can enable a higher stage on the
  // same edge that wraps this one.
  always_comb begin
    tc     = en & ((dir & at_max_s) | (~dir & at_zero_s));
    zero   = at_zero_s;
    cnt    = cnt_r;
    wrap_p = wrap_r;
  end

endmodule

// File: tb/tb_cnt_prog.sv
// tb_cnt_prog: scoreboard bench for cnt_prog.
// Stimulus drives inputs on the falling edge and queues the expected state
// after the next rising edge; a monitor pops and compares 1 time unit after
// each rising edge (or after an asynchronous reset event).

module tb_cnt_prog;

  typedef struct {
    int         id;    // 0: W3/MAX7, 1: W4/MAX9, 2: cascade
    int         cnt;
    logic       tc;
    logic       wrap;
    logic       zero;
    logic [1:0] aux;   // cascade low stage {wrap_p, zero}
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1, sat = 1'b0;
  logic [3:0] lv = 4'd0;
  logic       en_c = 1'b0;

  logic [2:0] cnt_a;
  logic       tc_a, wrap_a, zero_a;
  logic [3:0] cnt_b;
  logic       tc_b, wrap_b, zero_b;
  logic [3:0] cnt_lo, cnt_hi;
  logic       tc_lo, wrap_lo, zero_lo, tc_hi, wrap_hi, zero_hi;

  always #5 clk = ~clk;

  cnt_prog #(.WIDTH(3), .MAX(7), .RST_VAL(0)) u_a (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load),
    .load_val(lv[2:0]), .dir(dir), .sat(sat),
    .cnt(cnt_a), .tc(tc_a), .wrap_p(wrap_a), .zero(zero_a)
  );

  cnt_prog #(.WIDTH(4), .MAX(9), .RST_VAL(0)) u_b (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load),
    .load_val(lv), .dir(dir), .sat(sat),
    .cnt(cnt_b), .tc(tc_b), .wrap_p(wrap_b), .zero(zero_b)
  );

  cnt_prog #(.WIDTH(4), .MAX(9), .RST_VAL(0)) u_lo (
    .clk(clk), .rstn(rstn), .en(en_c), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .dir(1'b1), .sat(1'b0),
    .cnt(cnt_lo), .tc(tc_lo), .wrap_p(wrap_lo), .zero(zero_lo)
  );

  cnt_prog #(.WIDTH(4), .MAX(9), .RST_VAL(0)) u_hi (
    .clk(clk), .rstn(rstn), .en(tc_lo), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .dir(1'b1), .sat(1'b0),
    .cnt(cnt_hi), .tc(tc_hi), .wrap_p(wrap_hi), .zero(zero_hi)
  );

  // Monitor: compare every queued expectation against the selected DUT.
  initial begin
    exp_t       e;
    int         a_cnt;
    logic       a_tc, a_wrap, a_zero;
    logic [1:0] a_aux;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a_aux = 2'b00;
        if (e.id == 0) begin
          a_cnt = int'(cnt_a); a_tc = tc_a; a_wrap = wrap_a; a_zero = zero_a;
        end else if (e.id == 1) begin
          a_cnt = int'(cnt_b); a_tc = tc_b; a_wrap = wrap_b; a_zero = zero_b;
        end else begin
          a_cnt = int'({cnt_hi, cnt_lo}); a_tc = tc_hi; a_wrap = wrap_hi;
          a_zero = zero_hi; a_aux = {wrap_lo, zero_lo};
        end
        checks++;
        if (a_cnt !== e.cnt || a_tc !== e.tc || a_wrap !== e.wrap ||
            a_zero !== e.zero || a_aux !== e.aux) begin
          errors++;
          $display("FAIL %s @%0t: got cnt=%0d tc=%b wrap_p=%b zero=%b aux=%b, want cnt=%0d tc=%b wrap_p=%b zero=%b aux=%b",
                   e.nm, $time, a_cnt, a_tc, a_wrap, a_zero, a_aux,
                   e.cnt, e.tc, e.wrap, e.zero, e.aux);
        end
      end
    end
  end

  function automatic exp_t mk(input int id, input int c, input logic t,
                              input logic w, input logic z,
                              input logic [1:0] ax, input string nm);
    exp_t e;
    e.id = id; e.cnt = c; e.tc = t; e.wrap = w; e.zero = z; e.aux = ax; e.nm = nm;
    return e;
  endfunction

  // One clocked step on the shared single-counter inputs.
  task automatic step(input int id, input logic e_i, input logic c_i,
                      input logic l_i, input logic [3:0] lv_i,
                      input logic d_i, input logic s_i, input int ecnt,
                      input logic etc, input logic ewrap, input string nm);
    @(negedge clk);
    rstn = 1'b1; en_c = 1'b0;
    en = e_i; clr = c_i; load = l_i; lv = lv_i; dir = d_i; sat = s_i;
    sb_q.push_back(mk(id, ecnt, etc, ewrap, ecnt == 0, 2'b00, nm));
  endtask

  // Assert reset between edges and check both counters without a clock edge.
  task automatic async_rst(input string nm);
    @(negedge clk);
    rstn = 1'b0;
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 2'b00, nm));
    sb_q.push_back(mk(1, 0, 1'b0, 1'b0, 1'b1, 2'b00, nm));
    -> sample_ev;
  endtask

  initial begin
    int k, hi, lo;
    // Reset state
    async_rst("reset");

    // W3/MAX7 free-run 0..7,0,1 then to 5
    for (int i = 1; i <= 13; i++)
      step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, i % 8, (i % 8) == 7,
           i == 8, "freerun_w3");
    async_rst("async_rst_at5");

    // W4/MAX9 up 1..9,0,1,2
    for (int i = 1; i <= 12; i++)
      step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, i % 10, (i % 10) == 9,
           i == 10, "mod10_up");
    // Down from 2: 1,0,9,8 with wrap pulse after 0->9
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, "mod10_dn1");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "mod10_dn0");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 9, 1'b0, 1'b1, "mod10_dn9");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8, 1'b0, 1'b0, "mod10_dn8");

    // Saturate up from 8
    step(1, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 8, 1'b0, 1'b0, "sat_load8");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 9, 1'b1, 1'b0, "sat_up9a");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 9, 1'b1, 1'b0, "sat_up9b");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 9, 1'b1, 1'b0, "sat_up9c");
    // Saturate down from 1
    step(1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1, 1'b0, 1'b0, "sat_load1");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 1'b1, 1'b0, "sat_dn0a");
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 1'b1, 1'b0, "sat_dn0b");

    // Priority: clr over load over en
    step(1, 1'b1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 0, 1'b0, 1'b0, "prio_clr");
    step(1, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 6, 1'b0, 1'b0, "prio_load");

    // Load clamp and hold
    step(1, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 9, 1'b0, 1'b0, "clamp15");
    for (int i = 0; i < 3; i++)
      step(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 9, 1'b0, 1'b0, "hold");

    // Cascade: 100 steps from 00 back to 00, high stage wraps once
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      rstn = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; en_c = 1'b1;
      k = i; lo = k % 10; hi = (k / 10) % 10;
      sb_q.push_back(mk(2, hi * 16 + lo, (k % 100) == 99, k == 100, hi == 0,
                        {lo == 0, lo == 0}, "cascade"));
    end
    @(negedge clk);
    en_c = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
